// File: rtl/blur_pkg.sv
// -----------------------------------------------------------------------------
// blur_pkg
// Shared types and constants for the streaming box-blur filter.
//   blur_level_e : kernel selection (bypass, 3x3, 5x5)
//   RECIP_3/5    : fixed-point reciprocals of 9 and 25, scaled by 2^RECIP_SHIFT
//   LAT          : advancing cycles from accepted input to valid_out
//   pixel_t      : {r,g,b} pixel at the default 4-bit channel width
// -----------------------------------------------------------------------------
package blur_pkg;

  typedef enum logic [1:0] {
    BLUR_OFF = 2'd0,
    BLUR_3   = 2'd1,
    BLUR_5   = 2'd2
  } blur_level_e;

  localparam int unsigned RECIP_3     = 7282;  // round(2^16 / 9)
  localparam int unsigned RECIP_5     = 2621;  // round(2^16 / 25)
  localparam int unsigned RECIP_SHIFT = 16;
  localparam int unsigned LAT         = 3;

  localparam int unsigned PIX_CH_W = 4;

  typedef struct packed {
    logic [PIX_CH_W-1:0] r;
    logic [PIX_CH_W-1:0] g;
    logic [PIX_CH_W-1:0] b;
  } pixel_t;

  // Encoding 3 is not a distinct kernel; it selects the 5x5 window.
  function automatic blur_level_e decode_level(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return BLUR_OFF;
      2'd1:    return BLUR_3;
      default: return BLUR_5;
    endcase
  endfunction

endpackage

// File: rtl/blur_line_buffer.sv
// -----------------------------------------------------------------------------
// blur_line_buffer
// One image line of delay. Reads the word stored at i_addr combinationally and,
// when enabled, overwrites that same word with i_wdata at the clock edge, so
// o_rdata is the pixel written one line earlier at the same column.
//   clk      : clock
//   i_en     : write enable (accepted beat)
//   i_addr   : column address
//   i_wdata  : pixel to store
//   o_rdata  : pixel from the previous line at this column
// -----------------------------------------------------------------------------
module blur_line_buffer
  import blur_pkg::*;
#(
  parameter int DEPTH  = 320,
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_addr];

  // NOTE: the RAM has no reset so it maps onto memory primitives; stale words
  // are harmless because the top masks every window that could reach them.
  // NOTE: clocked state uses non-blocking <= so all flops sample pre-edge
  // values; blocking = is kept for combinational logic only.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/box_blur_filter.sv
// -----------------------------------------------------------------------------
// box_blur_filter
// Streaming RGB box blur with a runtime kernel (bypass, 3x3, 5x5) and a fixed
// three-stage pipeline: S1 window/tap capture, S2 per-channel sum, S3 scale and
// round. The window is causal: output (r,c) averages rows r-K+1..r and columns
// c-K+1..c; pixels too close to the top/left edge pass through unchanged.
//   clk, reset_n                         : clock, async active-low reset
//   valid_in, ready_out                  : upstream handshake
//   startofpacket_in, endofpacket_in     : frame delimiters
//   data_in                              : pixel {R,G,B}
//   blur_level                           : 0 bypass, 1 3x3, 2/3 5x5 (on sop)
//   ready_in, valid_out                  : downstream handshake
//   startofpacket_out, endofpacket_out   : delimiters aligned with data_out
//   data_out                             : filtered pixel
// -----------------------------------------------------------------------------
module box_blur_filter
  import blur_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int CH_W       = 4,
  parameter int KMAX       = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              startofpacket_in,
  input  logic              endofpacket_in,
  input  logic [3*CH_W-1:0] data_in,
  input  logic [1:0]        blur_level,
  input  logic              ready_in,
  output logic              valid_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  output logic [3*CH_W-1:0] data_out
);

  localparam int PIX_W = 3 * CH_W;
  localparam int SUM_W = CH_W + 5;
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CH_W-1:0] CH_MAX = '1;

  // The whole pipeline moves in lockstep with downstream ready.
  logic w_advance;
  logic w_accept;
  assign ready_out = ready_in;
  assign w_advance = ready_in;
  assign w_accept  = valid_in & ready_in;

  // ---------------------------------------------------------------------------
  // Position counters and per-frame kernel selection
  // ---------------------------------------------------------------------------
  logic [COL_W-1:0] r_col, w_col;
  logic [ROW_W-1:0] r_row, w_row;
  blur_level_e      r_level, w_level, w_level_req;
  logic             w_pass;
  int               w_rad;

  // NOTE: every always_comb output is given a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_level_req = decode_level(blur_level);
    if (KMAX < 5 && w_level_req == BLUR_5) begin
      w_level_req = BLUR_3;
    end
    // A sop beat is (0,0) and loads the new kernel, even mid-frame.
    w_col   = startofpacket_in ? '0 : r_col;
    w_row   = startofpacket_in ? '0 : r_row;
    w_level = startofpacket_in ? w_level_req : r_level;
    w_rad   = (w_level == BLUR_5) ? 4 : 2;
    w_pass  = (w_level == BLUR_OFF) || (int'(w_row) < w_rad) || (int'(w_col) < w_rad);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_level <= BLUR_OFF;
    end else if (w_accept) begin
      r_level <= w_level;
      if (endofpacket_in) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_col == COL_W'(IMG_WIDTH - 1)) begin
        r_col <= '0;
        // Without an eop the row count sticks at the last line.
        r_row <= (w_row == ROW_W'(IMG_HEIGHT - 1)) ? w_row : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line-buffer chain: w_col_vec[k] is row r-k at the current column
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] w_col_vec [KMAX];
  assign w_col_vec[0] = data_in;

  for (genvar k = 0; k < KMAX - 1; k++) begin : g_lb
    blur_line_buffer #(
      .DEPTH  (IMG_WIDTH),
      .WIDTH  (PIX_W),
      .ADDR_W (COL_W)
    ) u_lb (
      .clk     (clk),
      .i_en    (w_accept),
      .i_addr  (w_col),
      .i_wdata (w_col_vec[k]),
      .o_rdata (w_col_vec[k+1])
    );
  end

  // ---------------------------------------------------------------------------
  // S1: tap shift register, r_tap[row age][column age]; [0][0] is the pixel
  // just accepted. Shifts on accepted beats only so bubbles leave it intact.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] r_tap [KMAX][KMAX];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < KMAX; i++) begin
        r_tap[i][0] <= w_col_vec[i];
        for (int j = 1; j < KMAX; j++) begin
          r_tap[i][j] <= r_tap[i][j-1];
        end
      end
    end
  end

  logic        r_s1_valid, r_s1_sop, r_s1_eop, r_s1_pass;
  blur_level_e r_s1_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sop   <= 1'b0;
      r_s1_eop   <= 1'b0;
      r_s1_pass  <= 1'b0;
      r_s1_level <= BLUR_OFF;
    end else if (w_advance) begin
      r_s1_valid <= w_accept;
      r_s1_sop   <= w_accept & startofpacket_in;
      r_s1_eop   <= w_accept & endofpacket_in;
      r_s1_pass  <= w_pass;
      r_s1_level <= w_level;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: per-channel window sum (channel 0 = B in the low bits)
  // ---------------------------------------------------------------------------
  logic [SUM_W-1:0] w_sum [3];

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      w_sum[ch] = '0;
      for (int i = 0; i < KMAX; i++) begin
        for (int j = 0; j < KMAX; j++) begin
          if (r_s1_level == BLUR_5 || (i < 3 && j < 3)) begin
            w_sum[ch] = w_sum[ch] + SUM_W'(r_tap[i][j][ch*CH_W +: CH_W]);
          end
        end
      end
    end
  end

  logic             r_s2_valid, r_s2_sop, r_s2_eop, r_s2_pass;
  blur_level_e      r_s2_level;
  logic [PIX_W-1:0] r_s2_pix;
  logic [SUM_W-1:0] r_s2_sum [3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sop   <= 1'b0;
      r_s2_eop   <= 1'b0;
      r_s2_pass  <= 1'b0;
      r_s2_level <= BLUR_OFF;
      r_s2_pix   <= '0;
      for (int ch = 0; ch < 3; ch++) r_s2_sum[ch] <= '0;
    end else if (w_advance) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sop   <= r_s1_sop;
      r_s2_eop   <= r_s1_eop;
      r_s2_pass  <= r_s1_pass;
      r_s2_level <= r_s1_level;
      r_s2_pix   <= r_tap[0][0];
      for (int ch = 0; ch < 3; ch++) r_s2_sum[ch] <= w_sum[ch];
    end
  end

  // ---------------------------------------------------------------------------
  // S3: multiply by the reciprocal, round half up, saturate to channel max
  // ---------------------------------------------------------------------------
  logic [31:0]      w_recip;
  logic [31:0]      w_quot [3];
  logic [PIX_W-1:0] w_blur;

  always_comb begin
    w_recip = (r_s2_level == BLUR_5) ? 32'(RECIP_5) : 32'(RECIP_3);
    w_blur  = '0;
    for (int ch = 0; ch < 3; ch++) begin
      w_quot[ch] = (32'(r_s2_sum[ch]) * w_recip + (32'd1 << (RECIP_SHIFT - 1))) >> RECIP_SHIFT;
      if (w_quot[ch] > 32'(CH_MAX)) begin
        w_blur[ch*CH_W +: CH_W] = CH_MAX;
      end else begin
        w_blur[ch*CH_W +: CH_W] = w_quot[ch][CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out         <= 1'b0;
      startofpacket_out <= 1'b0;
      endofpacket_out   <= 1'b0;
      data_out          <= '0;
    end else if (w_advance) begin
      valid_out         <= r_s2_valid;
      startofpacket_out <= r_s2_sop;
      endofpacket_out   <= r_s2_eop;
      data_out          <= r_s2_pass ? r_s2_pix : w_blur;
    end
  end

endmodule

// File: tb/tb_box_blur_filter.sv
// -----------------------------------------------------------------------------
// tb_box_blur_filter
// Directed bench for box_blur_filter on a reduced 32x16 frame. Expected frames
// come from a small behavioural model of the causal box average; key pixels
// are also checked against hand-computed constants (0x56A, 0x347, 0x458).
// -----------------------------------------------------------------------------
module tb_box_blur_filter;
  import blur_pkg::*;

  localparam int W    = 32;
  localparam int H    = 16;
  localparam int N    = W * H;
  localparam int CH_W = 4;

  localparam pixel_t         GREY_PX = '{r: 4'h5, g: 4'h6, b: 4'hA};
  localparam logic [11:0]    GREY    = GREY_PX;
  localparam logic [11:0]    DIM3    = 12'h347;  // 6/9 of GREY, rounded
  localparam logic [11:0]    DIM5    = 12'h458;  // 20/25 of GREY, rounded

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        startofpacket_in = 1'b0;
  logic        endofpacket_in = 1'b0;
  logic [11:0] data_in = '0;
  logic [1:0]  blur_level = 2'd0;
  logic        ready_in = 1'b1;
  logic        valid_out;
  logic        startofpacket_out;
  logic        endofpacket_out;
  logic [11:0] data_out;

  box_blur_filter #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .CH_W       (CH_W),
    .KMAX       (5)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .valid_in          (valid_in),
    .ready_out         (ready_out),
    .startofpacket_in  (startofpacket_in),
    .endofpacket_in    (endofpacket_in),
    .data_in           (data_in),
    .blur_level        (blur_level),
    .ready_in          (ready_in),
    .valid_out         (valid_out),
    .startofpacket_out (startofpacket_out),
    .endofpacket_out   (endofpacket_out),
    .data_out          (data_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int first_valid_cyc;

  logic [11:0] in_pix  [N];
  logic [11:0] exp_pix [N];
  logic [11:0] q_data [$];
  bit          q_sop  [$];
  bit          q_eop  [$];

  // Output capture: a beat transfers at the next rising edge when
  // valid_out && ready_in; both are stable at the falling edge.
  always @(negedge clk) begin
    if (reset_n && valid_out && ready_in) begin
      q_data.push_back(data_out);
      q_sop.push_back(startofpacket_out);
      q_eop.push_back(endofpacket_out);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: causal KxK average with the fixed-point reciprocal
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] model_pix(input int r, input int c, input int k);
    int          s;
    int          q;
    logic [11:0] res;
    logic [11:0] p;
    if (k == 1 || r < k - 1 || c < k - 1) return in_pix[r*W + c];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      s = 0;
      for (int rr = r - k + 1; rr <= r; rr++) begin
        for (int cc = c - k + 1; cc <= c; cc++) begin
          p = in_pix[rr*W + cc];
          s += int'(p[ch*4 +: 4]);
        end
      end
      q = (s * ((k == 3) ? 7282 : 2621) + 32768) / 65536;
      if (q > 15) q = 15;
      res[ch*4 +: 4] = 4'(q);
    end
    return res;
  endfunction

  task automatic build_expected(input int k);
    for (int i = 0; i < N; i++) exp_pix[i] = model_pix(i / W, i % W, k);
  endtask

  task automatic fill_uniform();
    for (int i = 0; i < N; i++) in_pix[i] = GREY;
  endtask

  task automatic fill_gradient(input int seed);
    for (int i = 0; i < N; i++) in_pix[i] = 12'((i * 293 + seed) & 12'hFFF);
  endtask

  task automatic fill_black_column();
    for (int i = 0; i < N; i++) in_pix[i] = ((i % W) == 10) ? 12'h000 : GREY;
  endtask

  // Drives n_send pixels of in_pix as one frame (eop on pixel N-1). With stall
  // set, ready_in drops 5 of every 20 cycles and valid_in idles 5 cycles after
  // every 10 pixels; ready_out tracking and output hold are checked here.
  task automatic drive_frame(input int n_send, input logic [1:0] lvl_a, input int chg_at,
                             input logic [1:0] lvl_b, input bit stall, input bit drain);
    int          i = 0;
    int          cyc = 0;
    int          gap = 0;
    bit          rdy;
    logic [14:0] snap;
    first_valid_cyc = -1;
    while (i < n_send && cyc < 40 * N) begin
      rdy              = !(stall && (cyc % 20) >= 15);
      ready_in         = rdy;
      valid_in         = (gap == 0);
      data_in          = in_pix[i];
      startofpacket_in = (i == 0);
      endofpacket_in   = (i == N - 1);
      blur_level       = (i >= chg_at) ? lvl_b : lvl_a;
      if (stall) begin
        #1;
        n_checks++;
        if (ready_out !== rdy) begin
          n_errors++;
          $display("FAIL stall_ready_out cyc %0d: got %b, want %b", cyc, ready_out, rdy);
        end
      end
      snap = {valid_out, startofpacket_out, endofpacket_out, data_out};
      @(posedge clk); #1;
      if (stall && !rdy) begin
        n_checks++;
        if ({valid_out, startofpacket_out, endofpacket_out, data_out} !== snap) begin
          n_errors++;
          $display("FAIL stall_hold cyc %0d: got %h, want %h", cyc,
                   {valid_out, startofpacket_out, endofpacket_out, data_out}, snap);
        end
      end
      if (valid_out && first_valid_cyc < 0) first_valid_cyc = cyc + 1;
      if (gap > 0) gap--;
      else if (rdy) begin
        i++;
        if (stall && (i % 10) == 0) gap = 5;
      end
      cyc++;
    end
    if (i < n_send) begin
      n_checks++;
      n_errors++;
      $display("FAIL drive_timeout: sent %0d pixels, want %0d", i, n_send);
    end
    if (drain) begin
      valid_in         = 1'b0;
      startofpacket_in = 1'b0;
      endofpacket_in   = 1'b0;
      ready_in         = 1'b1;
      repeat (8) @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({valid_out, startofpacket_out, endofpacket_out, data_out} !== 15'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h, want 0",
               {valid_out, startofpacket_out, endofpacket_out, data_out});
    end
    ready_in = 1'b0; #1;
    n_checks++;
    if (ready_out !== 1'b0) begin
      n_errors++; $display("FAIL reset_ready_low: got %b, want 0", ready_out);
    end
    ready_in = 1'b1; #1;
    n_checks++;
    if (ready_out !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready_high: got %b, want 1", ready_out);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (valid_out !== 1'b0) begin
      n_errors++; $display("FAIL reset_idle_valid: got %b, want 0", valid_out);
    end
  endtask

  task automatic test_uniform();
    fill_uniform();
    q_data.delete(); q_sop.delete(); q_eop.delete();
    drive_frame(N, 2'd1, N, 2'd1, 1'b0, 1'b1);
    n_checks++;
    if (q_data.size() != N) begin
      n_errors++; $display("FAIL uniform_count: got %0d, want %0d", q_data.size(), N);
    end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== GREY || q_sop[i] !== (i == 0) || q_eop[i] !== (i == N - 1)) begin
        n_errors++;
        $display("FAIL uniform_pix[%0d]: got %h sop=%b eop=%b, want %h sop=%b eop=%b",
                 i, q_data[i], q_sop[i], q_eop[i], GREY, (i == 0), (i == N - 1));
      end
    end
  endtask

  task automatic test_bypass();
    fill_gradient(7);
    build_expected(1);
    q_data.delete(); q_sop.delete(); q_eop.delete();
    drive_frame(N, 2'd0, N, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if (first_valid_cyc != int'(LAT)) begin
      n_errors++; $display("FAIL bypass_latency: got %0d, want %0d", first_valid_cyc, LAT);
    end
    n_checks++;
    if (q_data.size() != N) begin
      n_errors++; $display("FAIL bypass_count: got %0d, want %0d", q_data.size(), N);
    end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp_pix[i] || q_sop[i] !== (i == 0) || q_eop[i] !== (i == N - 1)) begin
        n_errors++;
        $display("FAIL bypass_pix[%0d]: got %h sop=%b eop=%b, want %h", i, q_data[i],
                 q_sop[i], q_eop[i], exp_pix[i]);
      end
    end
  endtask

  task automatic test_black_column(input bit stall);
    int          rr [9] = '{2, 7, 15, 0, 1, 3, 3, 5, 5};
    int          cc [9] = '{10, 11, 12, 10, 11, 0, 1, 13, 9};
    logic [11:0] ev [9] = '{DIM3, DIM3, DIM3, 12'h000, GREY, GREY, GREY, GREY, GREY};
    fill_black_column();
    build_expected(3);
    q_data.delete(); q_sop.delete(); q_eop.delete();
    drive_frame(N, 2'd1, N, 2'd1, stall, 1'b1);
    n_checks++;
    if (q_data.size() != N) begin
      n_errors++; $display("FAIL column_count stall=%0d: got %0d, want %0d", stall, q_data.size(), N);
    end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp_pix[i] || q_sop[i] !== (i == 0) || q_eop[i] !== (i == N - 1)) begin
        n_errors++;
        $display("FAIL column_pix[%0d] stall=%0d: got %h sop=%b eop=%b, want %h", i, stall,
                 q_data[i], q_sop[i], q_eop[i], exp_pix[i]);
      end
    end
    if (q_data.size() == N) begin
      for (int t = 0; t < 9; t++) begin
        n_checks++;
        if (q_data[rr[t]*W + cc[t]] !== ev[t]) begin
          n_errors++;
          $display("FAIL column_point(%0d,%0d) stall=%0d: got %h, want %h", rr[t], cc[t], stall,
                   q_data[rr[t]*W + cc[t]], ev[t]);
        end
      end
    end
  endtask

  task automatic test_level_change();
    int          rr [8] = '{4, 9, 15, 3, 4, 6, 8, 0};
    int          cc [8] = '{10, 12, 14, 12, 15, 3, 9, 10};
    logic [11:0] ev [8] = '{DIM5, DIM5, DIM5, GREY, GREY, GREY, GREY, 12'h000};
    fill_black_column();
    // Frame A: 3x3 latched at sop; the request switches to 5x5 at pixel 100.
    build_expected(3);
    q_data.delete(); q_sop.delete(); q_eop.delete();
    drive_frame(N, 2'd1, 100, 2'd2, 1'b0, 1'b1);
    n_checks++;
    if (q_data.size() != N) begin
      n_errors++; $display("FAIL lvl_a_count: got %0d, want %0d", q_data.size(), N);
    end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp_pix[i]) begin
        n_errors++; $display("FAIL lvl_a_pix[%0d]: got %h, want %h", i, q_data[i], exp_pix[i]);
      end
    end
    // Frame B: 5x5 from its sop onwards (encoding 3 aliases to 5x5).
    build_expected(5);
    q_data.delete(); q_sop.delete(); q_eop.delete();
    drive_frame(N, 2'd3, N, 2'd3, 1'b0, 1'b1);
    n_checks++;
    if (q_data.size() != N) begin
      n_errors++; $display("FAIL lvl_b_count: got %0d, want %0d", q_data.size(), N);
    end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp_pix[i] || q_sop[i] !== (i == 0) || q_eop[i] !== (i == N - 1)) begin
        n_errors++; $display("FAIL lvl_b_pix[%0d]: got %h, want %h", i, q_data[i], exp_pix[i]);
      end
    end
    if (q_data.size() == N) begin
      for (int t = 0; t < 8; t++) begin
        n_checks++;
        if (q_data[rr[t]*W + cc[t]] !== ev[t]) begin
          n_errors++;
          $display("FAIL lvl_b_point(%0d,%0d): got %h, want %h", rr[t], cc[t],
                   q_data[rr[t]*W + cc[t]], ev[t]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    fill_gradient(1234);
    drive_frame(300, 2'd1, N, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if (valid_out !== 1'b1) begin
      n_errors++; $display("FAIL rst_pipe_full: got valid_out %b, want 1", valid_out);
    end
    reset_n  = 1'b0;
    valid_in = 1'b0;
    #1;
    n_checks++;
    if ({valid_out, data_out} !== 13'h0) begin
      n_errors++; $display("FAIL rst_immediate: got %h, want 0", {valid_out, data_out});
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (valid_out !== 1'b0) begin
        n_errors++; $display("FAIL rst_hold[%0d]: got valid_out %b, want 0", k, valid_out);
      end
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
    fill_gradient(99);
    build_expected(3);
    q_data.delete(); q_sop.delete(); q_eop.delete();
    drive_frame(N, 2'd1, N, 2'd1, 1'b0, 1'b1);
    n_checks++;
    if (q_data.size() != N) begin
      n_errors++; $display("FAIL rst_frame_count: got %0d, want %0d", q_data.size(), N);
    end
    for (int i = 0; i < N && i < q_data.size(); i++) begin
      n_checks++;
      if (q_data[i] !== exp_pix[i] || q_sop[i] !== (i == 0) || q_eop[i] !== (i == N - 1)) begin
        n_errors++; $display("FAIL rst_frame_pix[%0d]: got %h, want %h", i, q_data[i], exp_pix[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_bypass();
    test_black_column(1'b0);
    test_black_column(1'b1);
    test_level_change();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/box_blur_filter.md
Name: box_blur_filter

Overview:
- Streaming RGB box-blur filter with a runtime-selectable kernel: bypass, 3x3 or 5x5.
- Parametrised in frame size and channel width.
- Sits in the camera video path between the capture/colour stage and the VGA output stage.
- Uses the codebase's valid/ready/startofpacket/endofpacket streaming handshake, with full backpressure support.
- Buffers KMAX-1 image lines internally to form the kernel window.

Parameters:
- IMG_WIDTH, 320, pixels per line.
- IMG_HEIGHT, 240, lines per frame.
- CH_W, 4, bits per colour channel; pixel is {R,G,B}, 3*CH_W bits wide.
- KMAX, 5, largest supported kernel (odd, 3 or 5); sets the line-buffer count to KMAX-1.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  upstream pixel valid.
- ready_out  out  1  block can accept a pixel (to upstream).
- startofpacket_in  in  1  first pixel of frame.
- endofpacket_in  in  1  last pixel of frame.
- data_in  in  3*CH_W  pixel {R,G,B}.
- blur_level  in  2  0 = bypass, 1 = 3x3, 2 = 5x5, 3 = treated as 2.
- ready_in  in  1  downstream ready.
- valid_out  out  1  output pixel valid.
- startofpacket_out  out  1  first output pixel of frame.
- endofpacket_out  out  1  last output pixel of frame.
- data_out  out  3*CH_W  filtered pixel.

Behaviour:
- Reset: clk is the only clock; reset_n is asynchronous, active-low.
  - Reset clears to 0: valid_out, startofpacket_out, endofpacket_out, data_out, the row/col counters, the active level and all pipeline valid bits.
  - Line-buffer RAM is not cleared; stale contents are never used (see edge rule).
- Handshake:
  - ready_out = ready_in, combinational.
  - A beat is accepted when valid_in && ready_out.
  - The pipeline advances only when ready_in = 1. While ready_in = 0, every stage and all outputs hold unchanged.
  - Cycles with valid_in = 0 and ready_in = 1 advance a bubble (valid bit 0).
- Latency: fixed LAT = 3 advancing cycles from accepted input to the corresponding valid_out. The stages are:
  - S1: window/tap read.
  - S2: per-channel sum.
  - S3: scale and round.
- sop/eop pass through the pipeline with their pixel, and exactly one output beat is produced per accepted input.
- Counters:
  - col and row advance on each accepted beat; col wraps at IMG_WIDTH-1 to 0 and row then increments.
  - An accepted startofpacket_in forces that pixel to (0,0), including mid-frame (restart).
  - An accepted endofpacket_in resets the counters to (0,0) for the following pixel. A short frame is therefore tolerated.
  - row saturates at IMG_HEIGHT-1 if eop is missing.
- Mode: blur_level is latched into the active level on the accepted sop beat and held for the whole frame. Changes mid-frame are ignored.
- Window:
  - The window is causal: for kernel K and R = K-1, output pixel (r,c) averages inputs rows r-R..r and cols c-R..c.
  - Line buffers write data_in at address col on accepted beats; a tap shift register supplies the horizontal taps.
- Edge rule: if row < K-1 or col < K-1, or the level is bypass, data_out is the unmodified input pixel.
- Arithmetic, per channel:
  - sum width is CH_W + 5 bits.
  - out = (sum * RECIP_K + 2^15) >> 16, with RECIP_3 = 7282 and RECIP_5 = 2621.
  - The result is saturated to 2^CH_W - 1.
  - A uniform input value v gives v exactly.
- Reset mid-frame: the pipeline empties immediately. The next frame must start with sop; beats before it are processed as if at (0,0) onwards.

Decomposition:
- Package blur_pkg holds:
  - the level enum (BLUR_OFF, BLUR_3, BLUR_5);
  - the constants RECIP_3, RECIP_5, RECIP_SHIFT = 16 and LAT = 3;
  - the pixel struct type {r,g,b}.
- One sub-module, blur_line_buffer: a parametrised depth IMG_WIDTH x 3*CH_W single-port-read/write delay line with an enable. It is instantiated KMAX-1 times in a chain.

Test Plan:
- Uniform frame 0x56A, blur_level = 1, ready_in and valid_in held at 1 → 76800 outputs, all 0x56A, with startofpacket_out on output 0 only and endofpacket_out on output 76799 only.
- blur_level = 0, gradient frame → data_out equals data_in delayed 3 cycles, bit-exact.
- Grey 0x56A frame with black column 10, blur_level = 1 → for rows ≥ 2, cols 10..12 output 0x347; rows 0..1 and cols 0..1 pass through unchanged.
- ready_in low for 5 cycles every 15 pixels and valid_in low for 5 cycles every 10 pixels → ready_out tracks ready_in, outputs hold while stalled, and the output stream is identical to the unstalled run.
- blur_level changed 1 → 2 at pixel 1000 → the frame stays 3x3; the next frame, after sop, uses 5x5, and the black column yields 0x347-like dimming over cols 10..14 (values per 20/25 scaling).
- reset_n pulsed low at pixel 5000, then a new frame with sop → valid_out is 0 during reset, and the next frame output matches a clean-start golden model.
